// File: rtl/key_store_pkg.sv
// rtl/key_store_pkg.sv - shared state encoding and constants for the key store arbiter
package key_store_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ZERO  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    ZERO  = ST_ZERO
  } ks_state_e;

  localparam int HOST_ID    = 0;
  localparam int DENY_CNT_W = 8;

endpackage

// File: rtl/key_rr_arbiter.sv
// rtl/key_rr_arbiter.sv - combinational round-robin pick: first req at or above ptr, wrapping
module key_rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] rot_req;
  logic [2*NUM_REQ-1:0] rot_win;
  logic [NUM_REQ-1:0]   oh_rot;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_req = {req, req} >> ptr;
    oh_rot  = '0;
    valid   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && rot_req[i]) begin
        oh_rot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    rot_win = {{NUM_REQ{1'b0}}, oh_rot} << ptr;
    winner  = rot_win[NUM_REQ-1:0] | rot_win[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/key_store_arbiter.sv
// rtl/key_store_arbiter.sv - arbitrated key slot bank with locks and zeroize sweep
// Optional KEY_DENY_CNT_EN adds a saturating deny_cnt output.
module key_store_arbiter
  import key_store_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int NUM_SLOTS = 4,
  parameter int KEY_W     = 16,
  localparam int SLOT_AW  = $clog2(NUM_SLOTS),
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*SLOT_AW-1:0] req_slot,
  input  logic [NUM_REQ*KEY_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [KEY_W-1:0]           rsp_rdata,
  output logic                       rsp_err,
  input  logic                       lock_set,
  input  logic [SLOT_AW-1:0]         lock_slot,
  output logic [NUM_SLOTS-1:0]       lock_status,
  input  logic                       zeroize,
  output logic                       busy
`ifdef KEY_DENY_CNT_EN
  ,
  output logic [DENY_CNT_W-1:0]      deny_cnt
`endif
);

  ks_state_e           state;
  logic [PTR_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  arb_oh;
  logic                arb_valid;
  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win_idx;
  logic                acc_we;
  logic [SLOT_AW-1:0]  acc_slot;
  logic [KEY_W-1:0]    acc_wdata;
  logic [SLOT_AW-1:0]  sweep;
  logic [KEY_W-1:0]    slots [NUM_SLOTS];
  logic                sel_we;
  logic [SLOT_AW-1:0]  sel_slot;
  logic [KEY_W-1:0]    sel_wdata;
  logic [PTR_W-1:0]    sel_idx;
  logic                in_grant;
  logic                win_is_host;
  logic                sweep_last;

  key_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_oh),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_slot  = '0;
    sel_wdata = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_we    = req_we[i];
        sel_slot  = req_slot[i*SLOT_AW +: SLOT_AW];
        sel_wdata = req_wdata[i*KEY_W +: KEY_W];
        sel_idx   = PTR_W'(i);
      end
    end
  end

  // Responses are decoded from the registered access so the lock seen is the one at the start of GRANT.
  assign in_grant    = (state == GRANT);
  assign win_is_host = (win_idx == PTR_W'(HOST_ID));
  assign sweep_last  = (sweep == SLOT_AW'(NUM_SLOTS - 1));
  assign gnt         = in_grant ? win_oh : '0;
  assign rsp_valid   = in_grant;
  assign rsp_err     = in_grant && lock_status[acc_slot] && (acc_we || win_is_host);
  assign rsp_rdata   = (in_grant && !acc_we && !rsp_err) ? slots[acc_slot] : '0;
  assign busy        = (state == ZERO);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      win_oh    <= '0;
      win_idx   <= '0;
      acc_we    <= 1'b0;
      acc_slot  <= '0;
      acc_wdata <= '0;
      sweep     <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) slots[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (zeroize) begin
            state <= ZERO;
            sweep <= '0;
          end else if (arb_valid) begin
            state     <= GRANT;
            win_oh    <= arb_oh;
            win_idx   <= sel_idx;
            acc_we    <= sel_we;
            acc_slot  <= sel_slot;
            acc_wdata <= sel_wdata;
          end
        end
        GRANT: begin
          if (acc_we && !rsp_err) slots[acc_slot] <= acc_wdata;
          ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (zeroize) begin
            state <= ZERO;
            sweep <= '0;
          end else begin
            state <= IDLE;
          end
        end
        ZERO: begin
          slots[sweep] <= '0;
          sweep        <= sweep + 1'b1;
          if (sweep_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_status <= '0;
    end else if (busy) begin
      if (sweep_last) lock_status <= '0;
    end else if (lock_set) begin
      lock_status[lock_slot] <= 1'b1;
    end
  end

`ifdef KEY_DENY_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deny_cnt <= '0;
    end else if (rsp_err && (deny_cnt != {DENY_CNT_W{1'b1}})) begin
      deny_cnt <= deny_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_key_store_arbiter.sv
// tb/tb_key_store_arbiter.sv - scoreboard bench for key_store_arbiter (KEY_DENY_CNT_EN optional)
module tb_key_store_arbiter;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [5:0]  req_slot;
  logic [47:0] req_wdata;
  logic [2:0]  gnt;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        lock_set;
  logic [1:0]  lock_slot;
  logic [3:0]  lock_status;
  logic        zeroize;
  logic        busy;
`ifdef KEY_DENY_CNT_EN
  logic [7:0]  deny_cnt;
`endif

  key_store_arbiter #(.NUM_REQ(3), .NUM_SLOTS(4), .KEY_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_we      (req_we),
    .req_slot    (req_slot),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .lock_set    (lock_set),
    .lock_slot   (lock_slot),
    .lock_status (lock_status),
    .zeroize     (zeroize),
    .busy        (busy)
`ifdef KEY_DENY_CNT_EN
    ,
    .deny_cnt    (deny_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  gnt;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got gnt %b expected no response", gnt);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_gnt", 32'(gnt), 32'(mon_e.gnt));
        check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic apply_reset();
    resetn = 1'b0;
    req = '0; req_we = '0; req_slot = '0; req_wdata = '0;
    lock_set = 1'b0; lock_slot = '0; zeroize = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // One uncontended access; optional lock pulse placed on the GRANT cycle.
  task automatic access(input int r, input logic we, input int slot, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err, input int lock_at);
    int lat;
    bit seen;
    sb_q.push_back('{gnt: 3'(1 << r), rdata: exp_rd, err: exp_err});
    @(posedge clk); #1;
    req_we[r] = we;
    req_slot[r*2 +: 2] = 2'(slot);
    req_wdata[r*16 +: 16] = wd;
    req[r] = 1'b1;
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (gnt[r]) seen = 1;
    end
    check("gnt_latency", 32'(lat), 32'd2);
    if (seen && lock_at >= 0) begin
      lock_set = 1'b1;
      lock_slot = 2'(lock_at);
    end
    @(posedge clk); #1;
    req[r] = 1'b0;
    lock_set = 1'b0;
  endtask

  task automatic lock(input int s);
    @(posedge clk); #1;
    lock_set = 1'b1;
    lock_slot = 2'(s);
    @(posedge clk); #1;
    lock_set = 1'b0;
  endtask

  logic [2:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin : stim
    int cyc, k, last, busy_cnt, bad;
    bit seen;

    apply_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lock", 32'(lock_status), 32'd0);

    // Write then engine read
    access(0, 1'b1, 2, 16'hA5C3, 16'h0000, 1'b0, -1);
    access(1, 1'b0, 2, 16'h0000, 16'hA5C3, 1'b0, -1);

    // Lock enforcement
    access(0, 1'b1, 1, 16'h1234, 16'h0000, 1'b0, -1);
    lock(1);
    check("lock_after_set", 32'(lock_status), 32'h2);
    access(0, 1'b1, 1, 16'hFFFF, 16'h0000, 1'b1, -1);
    access(0, 1'b0, 1, 16'h0000, 16'h0000, 1'b1, -1);
    access(1, 1'b0, 1, 16'h0000, 16'h1234, 1'b0, -1);
    access(2, 1'b1, 1, 16'hDEAD, 16'h0000, 1'b1, -1);
    access(2, 1'b0, 1, 16'h0000, 16'h1234, 1'b0, -1);
    // Lock landing on the GRANT of a write to the same slot: write still completes
    access(2, 1'b1, 3, 16'h0BEE, 16'h0000, 1'b0, 3);
    check("lock_on_grant", 32'(lock_status), 32'hA);
    access(1, 1'b0, 3, 16'h0000, 16'h0BEE, 1'b0, -1);
    access(0, 1'b0, 3, 16'h0000, 16'h0000, 1'b1, -1);

    // Zeroize with all slots locked and an engine read pending
    lock(0);
    lock(2);
    check("lock_all", 32'(lock_status), 32'hF);
    sb_q.push_back('{gnt: 3'b100, rdata: 16'h0000, err: 1'b0});
    @(posedge clk); #1;
    zeroize = 1'b1;
    req_we[2] = 1'b0;
    req_slot[5:4] = 2'd2;
    req[2] = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    busy_cnt = 0; cyc = 0; seen = 0; bad = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        busy_cnt++;
        if (gnt != 3'b000) bad++;
        zeroize = (busy_cnt == 2);
      end
      if (gnt[2]) seen = 1;
    end
    check("zero_busy_cycles", 32'(busy_cnt), 32'd4);
    check("zero_no_gnt", 32'(bad), 32'd0);
    check("zero_pending_granted", 32'(seen), 32'd1);
    check("zero_lock_clear", 32'(lock_status), 32'd0);
    @(posedge clk); #1;
    req[2] = 1'b0;

    // Reset in the middle of a sweep
    access(0, 1'b1, 3, 16'h7777, 16'h0000, 1'b0, -1);
    lock(3);
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    busy_cnt = 0; cyc = 0;
    while (busy_cnt < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    check("mid_sweep_reached", 32'(busy_cnt), 32'd2);
    check("mid_sweep_lock", 32'(lock_status), 32'h8);
    resetn = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_lock", 32'(lock_status), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    access(0, 1'b0, 3, 16'h0000, 16'h0000, 1'b0, -1);
    access(1, 1'b0, 2, 16'h0000, 16'h0000, 1'b0, -1);

    // Contention with all requesters held
    apply_reset();
    for (int i = 0; i < 4; i++) sb_q.push_back('{gnt: rr_order[i], rdata: 16'h0000, err: 1'b0});
    @(posedge clk); #1;
    req_we = '0;
    req_slot = '0;
    req = 3'b111;
    cyc = 0; k = 0; last = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 3'b000) begin
        check("rr_order", 32'(gnt), 32'(rr_order[k]));
        if (k > 0) check("rr_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        k++;
      end
    end
    check("rr_count", 32'(k), 32'd4);
    @(posedge clk); #1;
    req = '0;

`ifdef KEY_DENY_CNT_EN
    apply_reset();
    check("deny_rst", 32'(deny_cnt), 32'd0);
    lock(0);
    for (int i = 0; i < 300; i++) access(1, 1'b1, 0, 16'(i), 16'h0000, 1'b1, -1);
    check("deny_sat", 32'(deny_cnt), 32'd255);
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("deny_zero_busy", 32'(busy), 32'd0);
    check("deny_after_zero", 32'(deny_cnt), 32'd255);
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
